// File: rtl/montgomery_mult_seq_if.sv
// Operand/result handshake bundle for the sequential Montgomery multiplier.
// The master side presents operands and consumes results; the slave is the multiplier.
interface montgomery_mult_seq_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] modulant;
  logic [DATA_WIDTH-1:0] rrm;
  logic                  mont_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out;
  logic                  err;
  logic                  busy;

  modport master (
    output in_valid, a, b, modulant, rrm, mont_mode, out_ready,
    input  in_ready, out_valid, out, err, busy
  );

  modport slave (
    input  in_valid, a, b, modulant, rrm, mont_mode, out_ready,
    output in_ready, out_valid, out, err, busy
  );
endinterface

// File: rtl/montgomery_mult_seq.sv
// Bit-serial radix-2 Montgomery multiplier.
// mont_mode=1: one pass, out = a*b*R^-1 mod n.
// mont_mode=0: second pass against R^2 mod n cancels R^-1, out = a*b mod n.
// An even modulus has no Montgomery inverse and is flagged with err.
module montgomery_mult_seq #(
  parameter int DATA_WIDTH = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  montgomery_mult_seq_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = DATA_WIDTH + 2;  // S < 4n at its peak, so two guard bits suffice
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, PASS1, FIX1, PASS2, FIX2, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, y_q, n_q, rrm_q;
  logic           mode_q;
  logic [SW-1:0]  s_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   out_q;
  logic           err_q;

  logic           accept;
  logic           last_bit;
  logic [SW-1:0]  s_add, s_odd, s_next;
  logic [W-1:0]   p;

  assign accept   = bus.in_valid && (state_q == IDLE);
  assign last_bit = (cnt_q == LAST);

  // One radix-2 step: add x[i]*y, add n if odd so the halving is exact.
  always_comb begin
    s_add  = s_q + (x_q[cnt_q] ? {2'b00, y_q} : '0);
    s_odd  = s_add + (s_add[0] ? {2'b00, n_q} : '0);
    s_next = s_odd >> 1;
    // S < 2n here, so one conditional subtract lands in [0, n); the low W
    // bits of the difference are exact because the result fits in W bits.
    p      = (s_q >= {2'b00, n_q}) ? (s_q[W-1:0] - n_q) : s_q[W-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_d = bus.modulant[0] ? PASS1 : DONE;
      end
      PASS1: if (last_bit) state_d = FIX1;
      FIX1:  state_d = mode_q ? DONE : PASS2;
      PASS2: if (last_bit) state_d = FIX2;
      FIX2:  state_d = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, accumulator, bit counter and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      n_q    <= '0;
      rrm_q  <= '0;
      mode_q <= 1'b0;
      s_q    <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          x_q    <= bus.a;
          y_q    <= bus.b;
          n_q    <= bus.modulant;
          rrm_q  <= bus.rrm;
          mode_q <= bus.mont_mode;
          s_q    <= '0;
          cnt_q  <= '0;
          if (!bus.modulant[0]) begin
            out_q <= '0;
            err_q <= 1'b1;
          end else begin
            err_q <= 1'b0;
          end
        end
        PASS1, PASS2: begin
          s_q   <= s_next;
          cnt_q <= cnt_q + CW'(1);
        end
        FIX1: begin
          if (mode_q) begin
            out_q <= p;
          end else begin
            // Multiplying by R^2 mod n restores the R factor the first pass removed.
            x_q   <= p;
            y_q   <= rrm_q;
            s_q   <= '0;
            cnt_q <= '0;
          end
        end
        FIX2: out_q <= p;
        default: ;
      endcase
    end
  end

  assign bus.out = out_q;
  assign bus.err = err_q;
endmodule
